sand_grid_engine: RTL
=====================

// Module: sand_grid_engine
// PURPOSE
//  Per-frame falling-sand update engine: scans a GRID_W x GRID_H cell grid held in byte memory over an
//  Avalon-MM master, applies gravity/flow rules per particle type and writes back swapped cells in place.
//  Parametrised successor to the fixed-size updater; sits between frame-sync control and scene RAM.
// PARAMETERS
//  GRID_W    160      cells per row (>=2)
//  GRID_H    120      rows (>=2)
//  ADDR_W    23       Avalon address width
//  BASE_ADDR 0        byte address of cell (0,0); cell (x,y) at BASE_ADDR + y*GRID_W + x
//  LFSR_SEED 16'hACE1 nonzero seed for direction LFSR (used only with SAND_LFSR_EN)
// PORTS
//  clock        in   1       system clock
//  reset        in   1       synchronous, active-low reset
//  start        in   1       pulse: begin one frame update; ignored while busy
//  busy         out  1       high from cycle after accepted start until done
//  done         out  1       one-cycle pulse when frame complete
//  frame_count  out  16      frames completed, wraps 16'hFFFF->0
//  address      out  ADDR_W  Avalon address
//  read         out  1       Avalon read strobe
//  write        out  1       Avalon write strobe
//  waitrequest  in   1       Avalon stall
//  readdata     in   8       Avalon read data, valid in cycle read && !waitrequest
//  writedata    out  8       Avalon write data
// BEHAVIOUR
//  Reset (reset==0 at clock edge): state IDLE; busy, done, read, write = 0; address, writedata = 0;
//   frame_count = 0; LFSR = LFSR_SEED. Reset mid-frame aborts immediately, grid left partially updated.
//  Cell byte: [1:0] type (EMPTY=0, SAND=1, WATER=2, WALL=3); [7:2] opaque, moved with the cell.
//  Avalon: read/write asserted with address/writedata stable until the cycle waitrequest is low; that
//   cycle completes the access; never read and write together; at most one access in flight.
//  Scan: rows y = GRID_H-2 down to 0 (bottom row never moves); x direction 0->W-1 on even frames,
//   W-1->0 on odd frames. Row base address decremented by GRID_W per row (no multiplier).
//  FSM: IDLE -> RD_SELF -> (EMPTY/WALL: NEXT) RD_BELOW -> (EMPTY: MOVE) RD_DIAG1 -> RD_DIAG2 ->
//   (WATER only) RD_SIDE1 -> RD_SIDE2 -> NEXT; MOVE = WR_DST then WR_SRC -> NEXT; NEXT -> RD_SELF or DONE;
//   DONE -> IDLE with done=1, frame_count+1, busy=0.
//  Rules: target first EMPTY of below, diag-pref, diag-other, (water) side-pref, side-other; none -> stay.
//   WR_DST writes self byte to target; WR_SRC writes 8'h00 to self. Each cell moves at most one step per frame.
//  Out-of-grid neighbours (x-1<0, x+1>=W) are treated as WALL without a bus access.
//  Sideways move in the scan direction advances x by 2 (skip moved particle; no double move).
//  Preference bit pref: 0 = left first, 1 = right first; sampled once per cell in RD_SELF.
//  Latency per cell with zero waitrequest: 1 cycle per access + 1 NEXT cycle.
//  start during busy: ignored. start in same cycle as done: ignored (accepted only in IDLE).
// CONFIGURATION
//  SAND_LFSR_EN defined: pref = bit0 of 16-bit Galois LFSR (taps 16,14,13,11) stepped once per cell.
//  SAND_LFSR_EN undefined: pref = x[0] ^ frame_count[0]; LFSR logic and LFSR_SEED unused.
// STRUCTURE
//  Package sand_pkg: typedef enum logic [1:0] cell_t {EMPTY,SAND,WATER,WALL}; typedef enum state_t;
//   localparam CELL_EMPTY_BYTE = 8'h00.
//  Sub-module sand_cell_rule (combinational): self/neighbour types + pref + edge flags -> target select
//   {NONE,BELOW,DIAG_L,DIAG_R,SIDE_L,SIDE_R}; engine reads neighbours lazily, rule mirrored in FSM order.
// TESTING (bench GRID_W=4, GRID_H=4, BASE_ADDR=0, slave with random 0-3 cycle waitrequest)
//  Sand at (1,0), rest EMPTY, 3 frames -> byte at addr 13 = 8'h01, all else 0, frame_count=3, 3 done pulses.
//  Sand at (1,2), SAND at (1,3), (0,3) EMPTY, (2,3) WALL -> after 1 frame sand at addr 12, addr 9 = 0.
//  Water 8'hFE at (0,3)? no: water 8'h02 at (1,2) on full floor of WALL row 3 -> moves sideways, byte preserved.
//  WALL 8'h03 at (2,1) over EMPTY -> never moves; every write seen only to EMPTY/moved cells.
//  Assert reset low mid-frame with write pending -> next cycle read=write=busy=0, state IDLE.
//  start pulsed while busy -> ignored; frame_count increments exactly once per accepted start.

Source files
------------

// File: rtl/sand_pkg.sv
// Shared types for the falling-sand grid engine.
//   cell_t  : particle type held in bits [1:0] of every cell byte
//   state_t : engine FSM states
//   tgt_t   : move target chosen by sand_cell_rule
package sand_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SAND  = 2'd1,
    WATER = 2'd2,
    WALL  = 2'd3
  } cell_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_SELF,
    RD_BELOW,
    RD_DIAG1,
    RD_DIAG2,
    RD_SIDE1,
    RD_SIDE2,
    WR_DST,
    WR_SRC,
    NEXT,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_BELOW,
    TGT_DIAG_L,
    TGT_DIAG_R,
    TGT_SIDE_L,
    TGT_SIDE_R
  } tgt_t;

  localparam logic [7:0] CELL_EMPTY_BYTE = 8'h00;

endpackage

// File: rtl/sand_cell_rule.sv
// Combinational move rule for one particle.
//   self_type            : type of the cell being updated
//   below/diag_*/side_*  : neighbour types (unread neighbours presented as WALL)
//   pref                 : 0 = try left first, 1 = try right first
//   at_left / at_right   : cell sits on the grid edge; off-grid neighbours act as WALL
//   target               : tgt_t encoding of the first EMPTY destination, or TGT_NONE
module sand_cell_rule
  import sand_pkg::*;
(
  input  logic [1:0] self_type,
  input  logic [1:0] below,
  input  logic [1:0] diag_l,
  input  logic [1:0] diag_r,
  input  logic [1:0] side_l,
  input  logic [1:0] side_r,
  input  logic       pref,
  input  logic       at_left,
  input  logic       at_right,
  output logic [2:0] target
);

  cell_t s, b, dl, dr, sl, sr;
  tgt_t  t;

  always_comb begin
    s  = cell_t'(self_type);
    b  = cell_t'(below);
    dl = at_left  ? WALL : cell_t'(diag_l);
    dr = at_right ? WALL : cell_t'(diag_r);
    sl = at_left  ? WALL : cell_t'(side_l);
    sr = at_right ? WALL : cell_t'(side_r);
    t  = TGT_NONE;
    if (s == SAND || s == WATER) begin
      if (b == EMPTY)                          t = TGT_BELOW;
      else if ((pref ? dr : dl) == EMPTY)      t = pref ? TGT_DIAG_R : TGT_DIAG_L;
      else if ((pref ? dl : dr) == EMPTY)      t = pref ? TGT_DIAG_L : TGT_DIAG_R;
      else if (s == WATER) begin
        if ((pref ? sr : sl) == EMPTY)         t = pref ? TGT_SIDE_R : TGT_SIDE_L;
        else if ((pref ? sl : sr) == EMPTY)    t = pref ? TGT_SIDE_L : TGT_SIDE_R;
      end
    end
  end

  assign target = t;

endmodule

// File: rtl/sand_grid_engine.sv
// Per-frame falling-sand updater over an Avalon-MM byte master.
// Scans rows GRID_H-2..0 (x ascending on even frames, descending on odd),
// reads neighbours lazily and swaps a particle into the first EMPTY target.
//   clock, reset (sync, active low), start -> busy, done, frame_count
//   address/read/write/writedata/waitrequest/readdata : Avalon-MM master
// Build option: SAND_LFSR_EN selects an LFSR for the left/right preference;
// otherwise preference = x[0] ^ frame_count[0].
module sand_grid_engine
  import sand_pkg::*;
#(
  parameter int          GRID_W    = 160,
  parameter int          GRID_H    = 120,
  parameter int          ADDR_W    = 23,
  parameter int          BASE_ADDR = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_count,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  input  logic [7:0]        readdata,
  output logic [7:0]        writedata
);

  localparam int XW = $clog2(GRID_W) + 1;
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0]     X_LAST    = XW'(GRID_W - 1);
  localparam logic [YW-1:0]     Y_TOP     = YW'(GRID_H - 2);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(GRID_W);
  localparam logic [ADDR_W-1:0] ROW_START = ADDR_W'(BASE_ADDR + (GRID_H - 2) * GRID_W);
  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);

  state_t            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] row_base;
  logic              skip2, pref_r, pref_src;
  logic [7:0]        self_byte;
  cell_t             nb_below, nb_d1, nb_d2, nb_s1, nb_s2;

  // Odd frames scan right-to-left.
  logic scan_desc;
  assign scan_desc = frame_count[0];

`ifdef SAND_LFSR_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock) begin
    if (!reset)
      lfsr <= LFSR_SEED;
    else if (state == RD_SELF && !waitrequest)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
  assign pref_src = lfsr[0];
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign pref_src    = x[0] ^ frame_count[0];
`endif

  cell_t rd_type;
  logic  at_left, at_right, is_water;
  assign rd_type  = cell_t'(readdata[1:0]);
  assign at_left  = (x == '0);
  assign at_right = (x == X_LAST);
  assign is_water = (self_byte[1:0] == WATER);

  logic [ADDR_W-1:0] a_self, a_below, a_bl, a_br, a_l, a_r;
  assign a_self  = row_base + ADDR_W'(x);
  assign a_below = a_self + ROW_STEP;
  assign a_bl    = a_below - A_ONE;
  assign a_br    = a_below + A_ONE;
  assign a_l     = a_self - A_ONE;
  assign a_r     = a_self + A_ONE;

  // Neighbour view for the rule: registered results with the byte arriving
  // this cycle substituted into its slot. d1/s1 are the preferred side.
  cell_t v_below, v_d1, v_d2, v_s1, v_s2;
  always_comb begin
    v_below = nb_below;
    v_d1    = nb_d1;
    v_d2    = nb_d2;
    v_s1    = nb_s1;
    v_s2    = nb_s2;
    case (state)
      RD_BELOW: v_below = rd_type;
      RD_DIAG1: v_d1    = rd_type;
      RD_DIAG2: v_d2    = rd_type;
      RD_SIDE1: v_s1    = rd_type;
      RD_SIDE2: v_s2    = rd_type;
      default:  ;
    endcase
  end

  logic [2:0] target_bits;
  tgt_t       target;
  sand_cell_rule u_rule (
    .self_type (self_byte[1:0]),
    .below     (v_below),
    .diag_l    (pref_r ? v_d2 : v_d1),
    .diag_r    (pref_r ? v_d1 : v_d2),
    .side_l    (pref_r ? v_s2 : v_s1),
    .side_r    (pref_r ? v_s1 : v_s2),
    .pref      (pref_r),
    .at_left   (at_left),
    .at_right  (at_right),
    .target    (target_bits)
  );
  assign target = tgt_t'(target_bits);

  // Next neighbour to probe: first in-grid one after the current probe.
  logic [4:0]        probe_ok;
  logic [2:0]        cur_idx, nxt_idx;
  logic              have_next;
  state_t            probe_state;
  logic [ADDR_W-1:0] probe_addr, tgt_addr;
  assign probe_ok[0] = 1'b1;
  assign probe_ok[1] = pref_r ? !at_right : !at_left;
  assign probe_ok[2] = pref_r ? !at_left  : !at_right;
  assign probe_ok[3] = is_water && probe_ok[1];
  assign probe_ok[4] = is_water && probe_ok[2];

  always_comb begin
    case (state)
      RD_DIAG1: cur_idx = 3'd1;
      RD_DIAG2: cur_idx = 3'd2;
      RD_SIDE1: cur_idx = 3'd3;
      RD_SIDE2: cur_idx = 3'd4;
      default:  cur_idx = 3'd0;
    endcase
    have_next = 1'b0;
    nxt_idx   = 3'd0;
    for (int unsigned i = 1; i < 5; i++) begin
      if (!have_next && probe_ok[i] && 3'(i) > cur_idx) begin
        have_next = 1'b1;
        nxt_idx   = 3'(i);
      end
    end
    case (nxt_idx)
      3'd1:    begin probe_state = RD_DIAG1; probe_addr = pref_r ? a_br : a_bl; end
      3'd2:    begin probe_state = RD_DIAG2; probe_addr = pref_r ? a_bl : a_br; end
      3'd3:    begin probe_state = RD_SIDE1; probe_addr = pref_r ? a_r  : a_l;  end
      3'd4:    begin probe_state = RD_SIDE2; probe_addr = pref_r ? a_l  : a_r;  end
      default: begin probe_state = RD_BELOW; probe_addr = a_below;              end
    endcase
    case (target)
      TGT_DIAG_L: tgt_addr = a_bl;
      TGT_DIAG_R: tgt_addr = a_br;
      TGT_SIDE_L: tgt_addr = a_l;
      TGT_SIDE_R: tgt_addr = a_r;
      default:    tgt_addr = a_below;
    endcase
  end

  // Step to the next cell; a sideways move in the scan direction skips the
  // destination so the particle is not moved twice in one frame.
  logic [XW-1:0] step, nx, x_first;
  logic          row_end;
  assign step    = skip2 ? XW'(2) : XW'(1);
  assign row_end = scan_desc ? (x < step) : ((x + step) > X_LAST);
  assign nx      = scan_desc ? (x - step) : (x + step);
  assign x_first = scan_desc ? X_LAST : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      read        <= 1'b0;
      write       <= 1'b0;
      address     <= '0;
      writedata   <= '0;
      frame_count <= '0;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      skip2       <= 1'b0;
      pref_r      <= 1'b0;
      self_byte   <= '0;
      nb_below    <= WALL;
      nb_d1       <= WALL;
      nb_d2       <= WALL;
      nb_s1       <= WALL;
      nb_s2       <= WALL;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          busy     <= 1'b1;
          read     <= 1'b1;
          x        <= x_first;
          y        <= Y_TOP;
          row_base <= ROW_START;
          skip2    <= 1'b0;
          address  <= ROW_START + ADDR_W'(x_first);
          state    <= RD_SELF;
        end
        RD_SELF: if (!waitrequest) begin
          self_byte <= readdata;
          pref_r    <= pref_src;
          skip2     <= 1'b0;
          nb_below  <= WALL;
          nb_d1     <= WALL;
          nb_d2     <= WALL;
          nb_s1     <= WALL;
          nb_s2     <= WALL;
          if (rd_type == EMPTY || rd_type == WALL) begin
            read  <= 1'b0;
            state <= NEXT;
          end else begin
            address <= a_below;
            state   <= RD_BELOW;
          end
        end
        RD_BELOW, RD_DIAG1, RD_DIAG2, RD_SIDE1, RD_SIDE2: if (!waitrequest) begin
          nb_below <= v_below;
          nb_d1    <= v_d1;
          nb_d2    <= v_d2;
          nb_s1    <= v_s1;
          nb_s2    <= v_s2;
          if (target != TGT_NONE) begin
            read      <= 1'b0;
            write     <= 1'b1;
            address   <= tgt_addr;
            writedata <= self_byte;
            skip2     <= (target == TGT_SIDE_R && !scan_desc) ||
                         (target == TGT_SIDE_L && scan_desc);
            state     <= WR_DST;
          end else if (have_next) begin
            address <= probe_addr;
            state   <= probe_state;
          end else begin
            read  <= 1'b0;
            state <= NEXT;
          end
        end
        WR_DST: if (!waitrequest) begin
          address   <= a_self;
          writedata <= CELL_EMPTY_BYTE;
          state     <= WR_SRC;
        end
        WR_SRC: if (!waitrequest) begin
          write <= 1'b0;
          state <= NEXT;
        end
        NEXT: begin
          if (!row_end) begin
            x       <= nx;
            address <= row_base + ADDR_W'(nx);
            read    <= 1'b1;
            state   <= RD_SELF;
          end else if (y == '0) begin
            state <= DONE;
          end else begin
            y        <= y - YW'(1);
            row_base <= row_base - ROW_STEP;
            x        <= x_first;
            address  <= row_base - ROW_STEP + ADDR_W'(x_first);
            read     <= 1'b1;
            state    <= RD_SELF;
          end
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          frame_count <= frame_count + 16'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
